// File: rtl/boa_mem_responder.sv
// boa_mem_responder
// Memory-side responder for the boa_mem_bus: a word-organised backing store
// with byte-lane writes, a fixed number of wait states per request and an
// injectable back-pressure input.
//
// Parameters
//   alen     address width in bytes
//   depth    number of 32-bit words; word index is addr[alen-1:2]
//   latency  wait states per request (0 = ready in the first request cycle)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   re        read request
//   we[3:0]   byte write enables, lane i is wdata[8i+7:8i]
//   addr      byte address (addr[1:0] ignored)
//   wdata     write data
//   hold      back-pressure: forces ready low and freezes the wait counter
//   ready     completion strobe (combinational)
//   rdata     read data, loaded at the edge closing a read completion
//   oob       sticky: a completed access targeted a word index >= depth
//   rd_count  completed reads (wraps)
//   wr_count  completed writes (wraps)
module boa_mem_responder #(
  parameter int unsigned alen    = 16,
  parameter int unsigned depth   = 1024,
  parameter int unsigned latency = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic [3:0]      we,
  input  logic [alen-1:0] addr,
  input  logic [31:0]     wdata,
  input  logic            hold,
  output logic            ready,
  output logic [31:0]     rdata,
  output logic            oob,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nx;
  logic [31:0]     cnt, cnt_nx;
  logic [31:0]     eff_cnt;
  logic            req, same, done, in_range;
  logic [alen-1:0] waddr;
  logic [AW-1:0]   widx;

  // Previous-cycle request, compared against the live request while waiting.
  logic            sh_re;
  logic [3:0]      sh_we;
  logic [alen-1:0] sh_waddr;
  logic [31:0]     sh_wdata;

  logic [31:0] mem [depth];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Word address; the byte offset bits shift out so they never matter.
  assign waddr    = addr >> 2;
  assign widx     = waddr[AW-1:0];
  assign in_range = 32'(waddr) < depth;

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    req      = re | (|we);
    // In WAIT the counter only carries over if the request is unchanged;
    // any difference makes this cycle the first cycle of a new request.
    same     = (state == WAIT) && (sh_re == re) && (sh_we == we) &&
               (sh_waddr == waddr) && (sh_wdata == wdata);
    eff_cnt  = same ? cnt : '0;
    done     = rst && req && !hold && (eff_cnt == latency);
    ready    = done;
    if (req && !done) begin
      state_nx = WAIT;
      cnt_nx   = hold ? eff_cnt : eff_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      oob      <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (done) begin
        if (re) begin
          rd_count <= rd_count + 32'd1;
          // Pre-write word: a combined read+write returns the old data.
          rdata    <= in_range ? mem[widx] : '0;
        end
        if (|we) wr_count <= wr_count + 32'd1;
        if (!in_range) oob <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    sh_re    <= re;
    sh_we    <= we;
    sh_waddr <= waddr;
    sh_wdata <= wdata;
  end

  // done is already gated by rst, so a reset mid-request never writes.
  always_ff @(posedge clk) begin
    if (done && in_range && (|we)) begin
      mem[widx] <= merge_lanes(mem[widx], wdata, we);
    end
  end

endmodule

// File: tb/tb_boa_mem_responder.sv
module tb_boa_mem_responder;

  localparam int N = 4;  // instance k has latency k

  logic        clk = 1'b0;
  logic        rst, re, hold;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic        rdy  [N];
  logic [31:0] rdat [N];
  logic        oobv [N];
  logic [31:0] rdc  [N];
  logic [31:0] wrc  [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    boa_mem_responder #(.alen(16), .depth(1024), .latency(g)) u_dut (
      .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
      .hold(hold), .ready(rdy[g]), .rdata(rdat[g]), .oob(oobv[g]),
      .rd_count(rdc[g]), .wr_count(wrc[g])
    );
  end

  typedef struct packed {
    logic        n;   // rst level
    logic        r;
    logic [3:0]  w;
    logic [15:0] a;
    logic [31:0] d;
    logic        h;
  } stim_t;

  function automatic stim_t mk(logic n, logic r, logic [3:0] w,
                               logic [15:0] a, logic [31:0] d, logic h);
    stim_t s;
    s.n = n; s.r = r; s.w = w; s.a = a; s.d = d; s.h = h;
    return s;
  endfunction

  // ---------------- reference model ----------------
  // Each instance: a request completes when it has already been seen, unchanged
  // and without hold, for exactly 'latency' earlier cycles since it began.
  bit [31:0] mm      [N][1024];
  bit [31:0] m_rdata [N];
  bit [31:0] m_rd    [N];
  bit [31:0] m_wr    [N];
  bit        m_oob   [N];
  bit        m_have  [N];
  bit [50:0] m_prev  [N];
  int        m_age   [N];
  int        m_a     [N];
  bit        e_rdy   [N];

  function automatic bit [50:0] cur_req();
    return {re, we, addr[15:2], wdata};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_rdata[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_oob[k] = 0;
      m_have[k] = 0; m_age[k] = 0;
    end
  endfunction

  function automatic void model_eval();
    bit rq;
    rq = re | (|we);
    for (int k = 0; k < N; k++) begin
      m_a[k]   = (m_have[k] && m_prev[k] == cur_req()) ? m_age[k] : 0;
      e_rdy[k] = rst && rq && !hold && (m_a[k] == k);
    end
  endfunction

  function automatic void model_commit();
    int idx;
    bit rq;
    rq  = re | (|we);
    idx = int'(addr) / 4;
    if (!rst) return;
    for (int k = 0; k < N; k++) begin
      if (e_rdy[k]) begin
        if (idx >= 1024) begin
          m_oob[k] = 1;
          if (re) m_rdata[k] = 0;
        end else begin
          if (re) m_rdata[k] = mm[k][idx];
          for (int b = 0; b < 4; b++)
            if (we[b]) mm[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (re) m_rd[k] = m_rd[k] + 1;
        if (|we) m_wr[k] = m_wr[k] + 1;
        m_have[k] = 0;
      end else if (rq) begin
        m_have[k] = 1;
        m_prev[k] = cur_req();
        m_age[k]  = m_a[k] + (hold ? 0 : 1);
      end else begin
        m_have[k] = 0;
      end
    end
  endfunction

  task automatic apply(input stim_t s);
    rst = s.n; re = s.r; we = s.w; addr = s.a; wdata = s.d; hold = s.h;
    if (!rst) model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t s[$];
    repeat (3) s.push_back(mk(0, 1, 4'hf, 16'h0040, 32'h1234_5678, 0));
    repeat (2) s.push_back(mk(1, 0, 4'h0, 16'h0000, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL reset ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== 97'd0) begin
          errors++; $display("FAIL reset outs[%0d] c%0d got=%h want=0", k, c, {rdat[k], oobv[k], rdc[k], wrc[k]});
        end
      end
    end
  endtask

  task automatic test_write_read();
    stim_t s[$];
    bit exp2;
    repeat (3) s.push_back(mk(1, 0, 4'hf, 16'h0008, 32'hdead_beef, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      exp2 = (c == 2) || (c == 6);
      checks++;
      if (rdy[2] !== exp2) begin
        errors++; $display("FAIL wr_rd ready_lat2 c%0d got=%b want=%b", c, rdy[2], exp2);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL wr_rd ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL wr_rd outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if ({rdat[2], rdc[2], wrc[2]} !== {32'hdead_beef, 32'd1, 32'd1}) begin
      errors++; $display("FAIL wr_rd final got=%h/%0d/%0d want=deadbeef/1/1", rdat[2], rdc[2], wrc[2]);
    end
  endtask

  task automatic test_byte_lanes();
    stim_t s[$];
    repeat (3) s.push_back(mk(1, 0, 4'hf, 16'h0010, 32'h1122_3344, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 0, 4'b0100, 16'h0010, 32'h00aa_0000, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h0010, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL lanes ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL lanes outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if (rdat[2] !== 32'h11aa_3344) begin
      errors++; $display("FAIL lanes rdata got=%h want=11aa3344", rdat[2]);
    end
  endtask

  task automatic test_backpressure();
    stim_t s[$];
    bit [31:0] rd0;
    bit exp1;
    rd0 = rdc[1];
    s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 1));
    s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      exp1 = (c == 4);
      checks++;
      if (rdy[1] !== exp1) begin
        errors++; $display("FAIL hold ready_lat1 c%0d got=%b want=%b", c, rdy[1], exp1);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL hold ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL hold outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if (rdc[1] - rd0 !== 32'd1) begin
      errors++; $display("FAIL hold rd_delta got=%0d want=1", rdc[1] - rd0);
    end
  endtask

  task automatic test_abort_change();
    stim_t s[$];
    bit [31:0] rd0;
    bit exp2;
    rd0 = rdc[2];
    s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 0));
    repeat (2) s.push_back(mk(1, 0, 4'h0, 16'h0008, 32'h0, 0));
    repeat (2) s.push_back(mk(1, 1, 4'h0, 16'h0008, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h0010, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      exp2 = (c == 7);
      checks++;
      if (rdy[2] !== exp2) begin
        errors++; $display("FAIL abort ready_lat2 c%0d got=%b want=%b", c, rdy[2], exp2);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL abort ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({rdat[2], rdc[2]} !== {32'h11aa_3344, rd0}) begin
          errors++; $display("FAIL abort after_drop got=%h/%0d want=11aa3344/%0d", rdat[2], rdc[2], rd0);
        end
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL abort outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if (rdc[2] - rd0 !== 32'd1) begin
      errors++; $display("FAIL abort rd_delta got=%0d want=1", rdc[2] - rd0);
    end
  endtask

  task automatic test_oob();
    stim_t s[$];
    checks++;
    if (oobv[2] !== 1'b0) begin
      errors++; $display("FAIL oob initial got=%b want=0", oobv[2]);
    end
    repeat (3) s.push_back(mk(1, 0, 4'hf, 16'h0000, 32'hcafe_f00d, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 0, 4'hf, 16'h1000, 32'h1234_5678, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h0000, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (3) s.push_back(mk(1, 1, 4'h0, 16'h1000, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL oob ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      if (c == 6) begin
        checks++;
        if (oobv[2] !== 1'b1) begin
          errors++; $display("FAIL oob flag got=%b want=1", oobv[2]);
        end
      end
      if (c == 10) begin
        checks++;
        if (rdat[2] !== 32'hcafe_f00d) begin
          errors++; $display("FAIL oob idx0 got=%h want=cafef00d", rdat[2]);
        end
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL oob outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if (rdat[2] !== 32'h0) begin
      errors++; $display("FAIL oob read got=%h want=0", rdat[2]);
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    bit exp3;
    repeat (4) s.push_back(mk(1, 0, 4'hf, 16'h0020, 32'h0102_0304, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    // c5: write starts, c6: reset, c7..: switch to a read of the same word
    s.push_back(mk(1, 0, 4'hf, 16'h0020, 32'h55aa_55aa, 0));
    s.push_back(mk(0, 0, 4'hf, 16'h0020, 32'h55aa_55aa, 0));
    repeat (4) s.push_back(mk(1, 1, 4'h0, 16'h0020, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    // c12: write starts, c13: reset, c14..c17 held after release
    s.push_back(mk(1, 0, 4'hf, 16'h0020, 32'h55aa_55aa, 0));
    s.push_back(mk(0, 0, 4'hf, 16'h0020, 32'h55aa_55aa, 0));
    repeat (4) s.push_back(mk(1, 0, 4'hf, 16'h0020, 32'h55aa_55aa, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    repeat (4) s.push_back(mk(1, 1, 4'h0, 16'h0020, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 16'h0, 32'h0, 0));
    for (int c = 0; c < s.size(); c++) begin
      apply(s[c]);
      #1; model_eval();
      exp3 = (c == 3) || (c == 10) || (c == 17) || (c == 22);
      checks++;
      if (rdy[3] !== exp3) begin
        errors++; $display("FAIL rstmid ready_lat3 c%0d got=%b want=%b", c, rdy[3], exp3);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL rstmid ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      if (c == 6 || c == 13) begin
        checks++;
        if ({rdat[3], oobv[3], rdc[3], wrc[3]} !== 97'd0) begin
          errors++; $display("FAIL rstmid zero c%0d got=%h want=0", c, {rdat[3], oobv[3], rdc[3], wrc[3]});
        end
      end
      if (c == 10) begin
        checks++;
        if (rdat[3] !== 32'h0102_0304) begin
          errors++; $display("FAIL rstmid no_write got=%h want=01020304", rdat[3]);
        end
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL rstmid outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
    checks++;
    if (rdat[3] !== 32'h55aa_55aa) begin
      errors++; $display("FAIL rstmid held_write got=%h want=55aa55aa", rdat[3]);
    end
  endtask

  task automatic test_random();
    stim_t cur;
    logic [15:0] addrs [7];
    addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h0010, 16'h0ffc, 16'h1000, 16'hfffc};
    cur = mk(1, 0, 4'h0, 16'h0, 32'h0, 0);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        cur.r = 1'b0; cur.w = 4'h0;
        case ($urandom_range(3))
          1: cur.r = 1'b1;
          2: cur.w = 4'($urandom_range(15, 1));
          3: begin cur.r = 1'b1; cur.w = 4'($urandom_range(15, 1)); end
          default: ;
        endcase
        cur.a = addrs[$urandom_range(6)] | 16'($urandom_range(3));
        cur.d = $urandom;
      end
      cur.h = ($urandom_range(4) == 0);
      apply(cur);
      #1; model_eval();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++; $display("FAIL rand ready[%0d] c%0d got=%b want=%b", k, c, rdy[k], e_rdy[k]);
        end
      end
      @(posedge clk); model_commit(); @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({rdat[k], oobv[k], rdc[k], wrc[k]} !== {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]}) begin
          errors++; $display("FAIL rand outs[%0d] c%0d got=%h want=%h", k, c,
                             {rdat[k], oobv[k], rdc[k], wrc[k]}, {m_rdata[k], m_oob[k], m_rd[k], m_wr[k]});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; re = 1'b0; we = 4'h0; addr = '0; wdata = '0; hold = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_abort_change();
    test_oob();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boa_mem_responder.md
# boa_mem_responder

Memory-side responder for `boa_mem_bus`, the far end of the bus that `boa_cache` drives on its external-memory port. It is a word-organised backing store with byte-lane writes, a parameterised wait-state count and optional injected back-pressure. The simulation tops use it in place of ad-hoc `ready = 1` memory stubs, so cache refill and write-back paths see realistic latency and real stored data.

## Interface
- `alen`, 16: address width of the bus, in bytes.
- `depth`, 1024: number of 32-bit words stored. Word index is `addr[alen-1:2]`.
- `latency`, 2: wait states per request. 0 means ready in the first cycle the request is visible.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `bus` interface `boa_mem_bus#(alen)`, responder side. Signals used:
  - `re` in 1: read request.
  - `we` in 4: byte write enables, lane i is `wdata[8i+7:8i]`.
  - `addr` in alen.
  - `wdata` in 32.
  - `ready` out 1.
  - `rdata` out 32.
- `hold` input 1: back-pressure injection. While high, `ready` is forced low and the wait counter does not advance.
- `oob` output 1: sticky flag, set by any completed access with word index ≥ `depth`.
- `rd_count` output 32: number of completed reads.
- `wr_count` output 32: number of completed writes (any `we` bit set).

## Operation
- A request is present when `re | (|we)`. `addr[1:0]` is ignored.
- States:
  - IDLE: no request.
    - Request present and `latency == 0` and `!hold`: completes this cycle.
    - Otherwise: go to WAIT with `cnt` = 1 at the next edge. `cnt` stays 0 if `hold` is high.
  - WAIT: `cnt` counts cycles the same request has been present with `hold` low.
    - `cnt == latency` and `!hold`: complete, then return to IDLE.
- Completion cycle: `ready` = 1, combinational from state, `cnt` and `hold`.
  - At the closing edge, bytes with `we[i]` are written.
  - If `re` is set, `rdata` is loaded from the pre-write word. A read+write therefore returns the old data.
- The request is captured in a shadow register (`re`, `we`, `addr`, `wdata`) on entry to WAIT.
  - If any request signal differs from the shadow during WAIT, the request is treated as new: `cnt` restarts at 0 and there are no side effects.
  - If the request drops during WAIT, it is aborted: return to IDLE, no write, `rdata` unchanged.
- Back-to-back requests: the cycle after a completion is cycle 0 of the next request. Throughput is one access per `latency+1` cycles.
- Out-of-range completion: `ready` asserts normally, the write is dropped, `rdata` is loaded with 0, and `oob` is set.
- Counters wrap at 2^32.
- Memory contents are not touched by reset and initialise to 0 at time 0.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `oob` 0, `rd_count` 0, `wr_count` 0.
- `ready` is 0 while `rst` is low, regardless of the request signals.
- Reset asserted mid-WAIT: the request is abandoned immediately with no write. After release, a still-present request restarts at cycle 0.
- Read latency: `rdata` is valid from the edge closing the `ready` cycle. It holds until the next completed read or reset.
- With `latency = 0` and `hold` low, `ready` is high in every cycle in which a request is present. `rdata` follows `addr` one cycle later.
- `hold` rising in the would-be completion cycle suppresses `ready`. Completion then happens in the first cycle `hold` is low.
- `ready` is never asserted with no request present.

## Test plan
- Reset then write with `latency=2`: write `we=4'hf`, `addr=16'h0008`, `wdata=32'hdead_beef`. `ready` is high in cycle 2 only. A following read of `0x0008` gives `ready` in cycle 2, and `rdata=32'hdead_beef` the next cycle. `wr_count=1`, `rd_count=1`.
- Byte lanes: write `32'h1122_3344` to `0x0010`, then `we=4'b0100`, `wdata=32'h00aa_0000`. A read of `0x0010` returns `32'h11aa_3344`.
- Back-pressure: `latency=1`, read, `hold` high in cycles 1–3. `ready` is high only in cycle 4 and `rd_count` increments once.
- Abort and change: drop `re` in cycle 1 of a `latency=2` read, giving no `ready` and no count change. Then change `addr` mid-WAIT; `ready` arrives 2 cycles after the change.
- Out-of-range: `depth=1024`, write to `addr=16'h1000` (index 1024). `ready` asserts and `oob=1`. Index 0 still reads its previous value, and a read of `0x1000` gives `rdata=0`.
- Reset mid-operation: assert `rst` low in cycle 1 of a `latency=3` write. The target word is unchanged and all outputs are 0. After release, the held request completes 3 cycles later.
